// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared AXI encodings for the instruction-side SRAM-to-AXI bridge.
package inst_sram_axi_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [1:0] AXI_LOCK_DEF   = 2'b00;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'h0;
  localparam logic [2:0] AXI_PROT_DEF   = 3'h0;

  function automatic logic [2:0] axi_size(
    input logic [1:0] s
  );
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/inst_sram_axi_bridge.sv
// SRAM-like fetch port to single-beat AXI4 reads, in-order.
// Optional INST_BRIDGE_ERR_EN adds inst_sram_err from rresp.
module inst_sram_axi_bridge
  import inst_sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID          = 4'h0,
  parameter int         MAX_OUTSTANDING = 2,
  parameter int         CNT_W           = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
`ifdef INST_BRIDGE_ERR_EN
  output logic        inst_sram_err,
`endif
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  logic        r_arvalid;
  logic [31:0] r_araddr;
  logic [2:0]  r_arsize;
  logic [CNT_W-1:0] r_cnt;
  logic        r_data_ok;
  logic [31:0] r_rdata;
  logic        w_addr_ok;
  logic        w_r_hs;
  logic        w_resp_err;
  logic        w_unused;

  assign w_addr_ok = inst_sram_req & ~inst_sram_wr
                   & (~r_arvalid | arready)
                   & (r_cnt < CNT_W'(MAX_OUTSTANDING));
  assign rready     = (r_cnt != '0);
  assign w_r_hs     = rvalid & rready;
  assign w_resp_err = (rresp != AXI_RESP_OKAY);

  assign inst_sram_addr_ok = w_addr_ok;
  assign inst_sram_data_ok = r_data_ok;
  assign inst_sram_rdata   = r_rdata;

  assign arid    = AXI_ID;
  assign araddr  = r_araddr;
  assign arlen   = 8'd0;
  assign arsize  = r_arsize;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_DEF;
  assign arcache = AXI_CACHE_DEF;
  assign arprot  = AXI_PROT_DEF;
  assign arvalid = r_arvalid;

  assign w_unused = ^{inst_sram_wstrb, inst_sram_wdata,
                      rid, rlast, w_resp_err};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_arvalid <= 1'b0;
      r_araddr  <= '0;
      r_arsize  <= '0;
      r_cnt     <= '0;
      r_data_ok <= 1'b0;
      r_rdata   <= '0;
    end else begin
      // a fresh accept reloads even while the old beat is handing off
      if (w_addr_ok) begin
        r_arvalid <= 1'b1;
        r_araddr  <= inst_sram_addr;
        r_arsize  <= axi_size(inst_sram_size);
      end else if (r_arvalid && arready) begin
        r_arvalid <= 1'b0;
      end
      r_data_ok <= w_r_hs;
      if (w_r_hs)
        r_rdata <= rdata;
      case ({w_addr_ok, r_data_ok})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

`ifdef INST_BRIDGE_ERR_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (!resetn)
      r_err <= 1'b0;
    else
      r_err <= w_r_hs & w_resp_err;
  end

  assign inst_sram_err = r_err;
`endif

endmodule

// File: tb/tb_inst_sram_axi_bridge.sv
// Directed bench for inst_sram_axi_bridge with an AXI slave model
// and an in-order scoreboard on data_ok.
module tb_inst_sram_axi_bridge;

`ifdef INST_BRIDGE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn;
  logic        req, wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        addr_ok, data_ok;
  logic [31:0] srdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst, arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic        tb_err;

  logic        ar_stall = 1'b0;
  logic        r_hold   = 1'b0;
  logic [1:0]  resp_val = 2'b00;

  int n_run  = 0;
  int n_fail = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ar_q[$];

  always #5 clk = ~clk;

  assign arready = ~ar_stall;
  assign rid     = 4'h0;
  assign rlast   = 1'b1;

  inst_sram_axi_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (req),
    .inst_sram_wr      (wr),
    .inst_sram_size    (size),
    .inst_sram_wstrb   (wstrb),
    .inst_sram_addr    (addr),
    .inst_sram_wdata   (wdata),
    .inst_sram_addr_ok (addr_ok),
    .inst_sram_data_ok (data_ok),
`ifdef INST_BRIDGE_ERR_EN
    .inst_sram_err     (tb_err),
`endif
    .inst_sram_rdata   (srdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

`ifndef INST_BRIDGE_ERR_EN
  assign tb_err = 1'b0;
`endif

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic take(input string tag);
    #1;
    chk(tag, {63'd0, addr_ok}, 64'd1);
    if (addr_ok)
      exp_q.push_back({ERR_EN && (resp_val != 2'b00), mem(addr)});
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (rready || exp_q.size() != 0); i++)
      @(negedge clk);
    #1;
    chk("drain_rready", {63'd0, rready}, 64'd0);
    chk("drain_sb", 64'(exp_q.size()), 64'd0);
  endtask

  // AXI slave: R follows accepted AR addresses in order
  initial begin
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        ar_q.delete();
        rvalid = 1'b0;
      end else begin
        rvalid = (ar_q.size() > 0) && !r_hold;
        rresp  = resp_val;
        if (rvalid)
          rdata = mem(ar_q[0]);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (resetn) begin
        if (rvalid && rready)
          void'(ar_q.pop_front());
        if (arvalid && arready)
          ar_q.push_back(araddr);
      end
    end
  end

  // scoreboard
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (data_ok) begin
        chk("sb_nonempty", {63'd0, exp_q.size() != 0}, 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("sb_data", {31'd0, tb_err, srdata}, {31'd0, e});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int dcyc, acyc;
    resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd2;
    wstrb = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
    chk("rst_araddr", {32'd0, araddr}, 64'd0);
    chk("rst_arsize", {61'd0, arsize}, 64'd0);
    chk("rst_data_ok", {63'd0, data_ok}, 64'd0);
    chk("rst_rdata", {32'd0, srdata}, 64'd0);
    chk("rst_rready", {63'd0, rready}, 64'd0);
    chk("const_ar", {arid, arlen, arburst, arlock, arcache, arprot},
        {4'h0, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0});
    @(negedge clk); resetn = 1'b1;

    // single fetch
    @(negedge clk); req = 1'b1; addr = 32'h1c00_0000;
    take("t1_addr_ok");
    @(negedge clk); req = 1'b0; #1;
    chk("t1_arvalid", {63'd0, arvalid}, 64'd1);
    chk("t1_araddr", {32'd0, araddr}, 64'h1c00_0000);
    chk("t1_arsize", {61'd0, arsize}, 64'd2);
    chk("t1_no_data1", {63'd0, data_ok}, 64'd0);
    @(negedge clk); #1;
    chk("t1_no_data2", {63'd0, data_ok}, 64'd0);
    @(negedge clk); #1;
    chk("t1_data_ok", {63'd0, data_ok}, 64'd1);
    chk("t1_rdata", {32'd0, srdata}, {32'd0, mem(32'h1c00_0000)});
    @(negedge clk); #1;
    chk("t1_data_ok_pulse", {63'd0, data_ok}, 64'd0);
    chk("t1_cnt_zero", {63'd0, rready}, 64'd0);

    // write request is never accepted
    @(negedge clk); req = 1'b1; wr = 1'b1; addr = 32'h1c00_0040;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wr_no_addr_ok", {63'd0, addr_ok}, 64'd0);
      @(negedge clk);
    end
    req = 1'b0; wr = 1'b0; #1;
    chk("wr_no_arvalid", {63'd0, arvalid}, 64'd0);

    // outstanding limit
    r_hold = 1'b1;
    @(negedge clk); req = 1'b1; addr = 32'h1c00_0100;
    take("t2_a0");
    @(negedge clk); addr = 32'h1c00_0104;
    take("t2_a1");
    @(negedge clk); addr = 32'h1c00_0108; #1;
    chk("t2_full", {63'd0, addr_ok}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("t2_full_hold", {63'd0, addr_ok}, 64'd0);
      chk("t2_rready", {63'd0, rready}, 64'd1);
    end
    @(negedge clk); r_hold = 1'b0;
    dcyc = -1; acyc = -1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (data_ok && dcyc < 0) dcyc = i;
      if (addr_ok) begin
        acyc = i;
        exp_q.push_back({ERR_EN && (resp_val != 2'b00), mem(addr)});
        break;
      end
      @(negedge clk);
    end
    chk("t2_third_after_data_ok", 64'(acyc), 64'(dcyc + 1));
    @(negedge clk); req = 1'b0;
    drain();

    // AR stall and back-to-back reload
    @(negedge clk); ar_stall = 1'b1; req = 1'b1; addr = 32'h1c00_0200;
    take("t3_b0");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); addr = 32'h1c00_0204; #1;
      chk("t3_arvalid_hold", {63'd0, arvalid}, 64'd1);
      chk("t3_araddr_hold", {32'd0, araddr}, 64'h1c00_0200);
      chk("t3_stall_no_ok", {63'd0, addr_ok}, 64'd0);
    end
    @(negedge clk); ar_stall = 1'b0;
    take("t3_reload");
    @(negedge clk); req = 1'b0; #1;
    chk("t3_arvalid_kept", {63'd0, arvalid}, 64'd1);
    chk("t3_araddr_new", {32'd0, araddr}, 64'h1c00_0204);
    drain();

    // addr_ok and data_ok together, ordering
    @(negedge clk); req = 1'b1; addr = 32'h1c00_0000;
    take("t4_a0");
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk); req = 1'b1; addr = 32'h1c00_0004; #1;
    chk("t4_d0_ok", {63'd0, data_ok}, 64'd1);
    chk("t4_d0", {32'd0, srdata}, {32'd0, mem(32'h1c00_0000)});
    exp_q.push_back({ERR_EN && (resp_val != 2'b00), mem(addr)});
    chk("t4_same_cycle_ok", {63'd0, addr_ok}, 64'd1);
    @(negedge clk); req = 1'b0; #1;
    chk("t4_cnt_one", {63'd0, rready}, 64'd1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t4_d1_ok", {63'd0, data_ok}, 64'd1);
    chk("t4_d1", {32'd0, srdata}, {32'd0, mem(32'h1c00_0004)});
    @(negedge clk); #1;
    chk("t4_cnt_zero", {63'd0, rready}, 64'd0);

    // reset in the middle of traffic
    r_hold = 1'b1;
    @(negedge clk); req = 1'b1; addr = 32'h1c00_0300;
    take("t5_c0");
    @(negedge clk); addr = 32'h1c00_0304;
    take("t5_c1");
    @(negedge clk); req = 1'b0; ar_stall = 1'b1; #1;
    chk("t5_pre_arvalid", {63'd0, arvalid}, 64'd1);
    chk("t5_pre_rready", {63'd0, rready}, 64'd1);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk); #1;
    chk("t5_arvalid", {63'd0, arvalid}, 64'd0);
    chk("t5_araddr", {32'd0, araddr}, 64'd0);
    chk("t5_arsize", {61'd0, arsize}, 64'd0);
    chk("t5_data_ok", {63'd0, data_ok}, 64'd0);
    chk("t5_rdata", {32'd0, srdata}, 64'd0);
    chk("t5_rready", {63'd0, rready}, 64'd0);
    @(negedge clk); resetn = 1'b1; ar_stall = 1'b0; r_hold = 1'b0;
    @(negedge clk); req = 1'b1; addr = 32'h1c00_0308;
    take("t5_after");
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_after_ok", {63'd0, data_ok}, 64'd1);
    chk("t5_after_data", {32'd0, srdata}, {32'd0, mem(32'h1c00_0308)});
    drain();

`ifdef INST_BRIDGE_ERR_EN
    resp_val = 2'b10;
    @(negedge clk); req = 1'b1; addr = 32'h1c00_0400;
    take("t6_req");
    @(negedge clk); req = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t6_data_ok", {63'd0, data_ok}, 64'd1);
    chk("t6_err", {63'd0, tb_err}, 64'd1);
    @(negedge clk); #1;
    chk("t6_err_clear", {63'd0, tb_err}, 64'd0);
    resp_val = 2'b00;
    drain();
`endif

    chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
